// File: rtl/aes_kat_pkg.sv
// Shared constants and vector table for the AES known-answer-test sequencer.
// Vectors are the FIPS-197 Appendix C examples; keys are left-aligned in 256 bits.
package aes_kat_pkg;

    localparam int unsigned NumTests = 6;

    typedef enum logic [1:0] {
        KeyLen128 = 2'd0,
        KeyLen192 = 2'd1,
        KeyLen256 = 2'd2
    } keylen_e;

    localparam logic [2:0] TestE128 = 3'd0;
    localparam logic [2:0] TestD128 = 3'd1;
    localparam logic [2:0] TestE192 = 3'd2;
    localparam logic [2:0] TestD192 = 3'd3;
    localparam logic [2:0] TestE256 = 3'd4;
    localparam logic [2:0] TestD256 = 3'd5;
    // Sentinel index meaning "no further enabled test"
    localparam logic [2:0] TestNone = 3'd6;

    localparam logic [127:0] KatPlain  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KatKey128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] KatKey192 =
        192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KatKey256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KatCt128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KatCt192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] KatCt256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct packed {
        logic          decrypt;
        keylen_e       keylen;
        logic [255:0]  key;
        logic [127:0]  din;
        logic [127:0]  expected;
    } kat_vec_t;

    function automatic kat_vec_t kat_vector(logic [2:0] idx);
        kat_vec_t v;
        v = '0;
        unique case (idx)
            TestE128: v = '{1'b0, KeyLen128, {KatKey128, 128'h0}, KatPlain, KatCt128};
            TestD128: v = '{1'b1, KeyLen128, {KatKey128, 128'h0}, KatCt128, KatPlain};
            TestE192: v = '{1'b0, KeyLen192, {KatKey192, 64'h0}, KatPlain, KatCt192};
            TestD192: v = '{1'b1, KeyLen192, {KatKey192, 64'h0}, KatCt192, KatPlain};
            TestE256: v = '{1'b0, KeyLen256, KatKey256, KatPlain, KatCt256};
            TestD256: v = '{1'b1, KeyLen256, KatKey256, KatCt256, KatPlain};
            default:  v = '0;
        endcase
        return v;
    endfunction

    // Lowest enabled test index at or above 'from', or TestNone.
    function automatic logic [2:0] next_enabled(logic [NumTests-1:0] mask, logic [2:0] from);
        logic [2:0] r;
        r = TestNone;
        for (int i = int'(NumTests) - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational test-index to vector lookup, keeping the sequencer FSM vector-agnostic.
module aes_kat_rom
    import aes_kat_pkg::*;
(
    input  logic [2:0]   idx,
    output logic         decrypt,
    output logic [1:0]   keylen,
    output logic [255:0] key,
    output logic [127:0] din,
    output logic [127:0] expected
);

    kat_vec_t vec;

    assign vec      = kat_vector(idx);
    assign decrypt  = vec.decrypt;
    assign keylen   = vec.keylen;
    assign key      = vec.key;
    assign din      = vec.din;
    assign expected = vec.expected;

endmodule

// File: rtl/aes_kat_sequencer.sv
// Time-multiplexed AES known-answer-test controller driving one shared engine.
// Optional per-test watchdog enabled by defining AES_KAT_TIMEOUT_EN.
module aes_kat_sequencer
    import aes_kat_pkg::*;
#(
    parameter logic [NumTests-1:0] TEST_MASK      = 6'b111111,
    parameter int unsigned         TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [NumTests-1:0] pass,
    output logic                all_pass,
    output logic                timeout,
    output logic                core_req,
    output logic                core_decrypt,
    output logic [1:0]          core_keylen,
    output logic [255:0]        core_key,
    output logic [127:0]        core_in,
    input  logic                core_ack,
    input  logic                core_rsp_valid,
    input  logic [127:0]        core_rsp_data
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StDone} state_t;

    state_t              state_q;
    logic [2:0]          idx_q;
    logic                match_q;
    logic [2:0]          first_idx;
    logic [2:0]          next_idx;
    logic [2:0]          rom_idx;
    logic                launch;
    logic                expired;
    logic [NumTests-1:0] pass_chk;

    logic                rom_decrypt;
    logic [1:0]          rom_keylen;
    logic [255:0]        rom_key;
    logic [127:0]        rom_din;
    logic [127:0]        rom_expected;

    assign first_idx = next_enabled(TEST_MASK, 3'd0);
    assign next_idx  = next_enabled(TEST_MASK, idx_q + 3'd1);

    // WAIT needs the current vector's expected result; IDLE/CHECK preload the next vector.
    assign rom_idx = (state_q == StWait) ? idx_q :
                     (state_q == StIdle) ? first_idx : next_idx;

    assign launch = ((state_q == StIdle) && start && (first_idx != TestNone)) ||
                    ((state_q == StCheck) && (next_idx != TestNone));

    always_comb begin
        pass_chk        = pass;
        pass_chk[idx_q] = match_q;
    end

    aes_kat_rom u_rom (
        .idx      (rom_idx),
        .decrypt  (rom_decrypt),
        .keylen   (rom_keylen),
        .key      (rom_key),
        .din      (rom_din),
        .expected (rom_expected)
    );

`ifdef AES_KAT_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_q;

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            tmo_q <= '0;
        end else if (state_q == StIssue || state_q == StWait) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign expired = (state_q == StIssue || state_q == StWait) &&
                     (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            match_q      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= '0;
            all_pass     <= 1'b0;
            timeout      <= 1'b0;
            core_req     <= 1'b0;
            core_decrypt <= 1'b0;
            core_keylen  <= '0;
            core_key     <= '0;
            core_in      <= '0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                idx_q        <= rom_idx;
                core_req     <= 1'b1;
                core_decrypt <= rom_decrypt;
                core_keylen  <= rom_keylen;
                core_key     <= rom_key;
                core_in      <= rom_din;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        pass     <= '0;
                        all_pass <= 1'b0;
                        timeout  <= 1'b0;
                        if (launch) begin
                            busy    <= 1'b1;
                            state_q <= StIssue;
                        end else begin
                            all_pass <= &(~TEST_MASK);
                            done     <= 1'b1;
                            state_q  <= StDone;
                        end
                    end
                end
                StIssue: begin
                    if (core_ack) begin
                        core_req <= 1'b0;
                        state_q  <= StWait;
                    end else if (expired) begin
                        core_req <= 1'b0;
                        match_q  <= 1'b0;
                        timeout  <= 1'b1;
                        state_q  <= StCheck;
                    end
                end
                StWait: begin
                    if (core_rsp_valid) begin
                        match_q <= (core_rsp_data == rom_expected);
                        state_q <= StCheck;
                    end else if (expired) begin
                        match_q <= 1'b0;
                        timeout <= 1'b1;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    pass <= pass_chk;
                    if (launch) begin
                        state_q <= StIssue;
                    end else begin
                        all_pass <= &(pass_chk | ~TEST_MASK);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Directed self-checking bench for aes_kat_sequencer with a behavioural AES core model.
module tb_aes_kat_sequencer;

    localparam logic [127:0] Pt     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                       64'h0};
    localparam logic [255:0] K256   =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] BadRsp = 128'hbadbadbadbadbadbadbadbadbadbadba;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_m = 1'b0;

    always #5 clk = ~clk;

    // Main DUT signals
    logic         busy, done, all_pass, timeout;
    logic [5:0]   pass;
    logic         core_req, core_decrypt, core_ack, core_rsp_valid;
    logic [1:0]   core_keylen;
    logic [255:0] core_key;
    logic [127:0] core_in, core_rsp_data;

    // Masked DUT signals
    logic         busy_m, done_m, all_pass_m, timeout_m;
    logic [5:0]   pass_m;
    logic         req_m, dec_m, ack_m, vld_m;
    logic [1:0]   kl_m;
    logic [255:0] key_m;
    logic [127:0] in_m, data_m;

    aes_kat_sequencer #(.TEST_MASK(6'b111111), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .all_pass(all_pass), .timeout(timeout), .core_req(core_req),
        .core_decrypt(core_decrypt), .core_keylen(core_keylen), .core_key(core_key),
        .core_in(core_in), .core_ack(core_ack), .core_rsp_valid(core_rsp_valid),
        .core_rsp_data(core_rsp_data)
    );

    aes_kat_sequencer #(.TEST_MASK(6'b010001)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .busy(busy_m), .done(done_m), .pass(pass_m),
        .all_pass(all_pass_m), .timeout(timeout_m), .core_req(req_m),
        .core_decrypt(dec_m), .core_keylen(kl_m), .core_key(key_m),
        .core_in(in_m), .core_ack(ack_m), .core_rsp_valid(vld_m),
        .core_rsp_data(data_m)
    );

    // Correct AES for the six known vectors only; anything else yields a bad result.
    function automatic logic [127:0] ref_aes(logic dec, logic [1:0] kl, logic [255:0] key,
                                             logic [127:0] din);
        logic [255:0] k;
        logic [127:0] ct;
        case (kl)
            2'd0: begin k = K128; ct = C128; end
            2'd1: begin k = K192; ct = C192; end
            2'd2: begin k = K256; ct = C256; end
            default: return BadRsp;
        endcase
        if (key !== k) return BadRsp;
        if (!dec && din === Pt) return ct;
        if (dec && din === ct) return Pt;
        return BadRsp;
    endfunction

    // Main core model: ack on the ack_dly-th request cycle, response rsp_dly cycles later
    int   ack_dly = 1;
    int   rsp_dly = 1;
    bit   corrupt_d192 = 1'b0;
    bit   drop_e192 = 1'b0;
    int   req_cnt = 0;
    int   wait_cnt = 0;
    logic pend = 1'b0;
    logic [127:0] rsp_q = '0;
    int   n_hs = 0;
    int   n_done = 0;
    int   unstable = 0;
    logic held = 1'b0;
    logic [386:0] held_fields = '0;

    assign core_ack       = core_req && (req_cnt == ack_dly - 1);
    assign core_rsp_valid = pend && (wait_cnt == rsp_dly - 1);
    assign core_rsp_data  = rsp_q;

    always @(posedge clk) begin
        if (rst) begin
            req_cnt  <= 0;
            wait_cnt <= 0;
            pend     <= 1'b0;
        end else begin
            req_cnt <= (core_req && !core_ack) ? req_cnt + 1 : 0;
            if (core_req && core_ack) begin
                n_hs     <= n_hs + 1;
                pend     <= !(drop_e192 && !core_decrypt && core_keylen == 2'd1);
                wait_cnt <= 0;
                rsp_q    <= ref_aes(core_decrypt, core_keylen, core_key, core_in) ^
                            {127'b0, corrupt_d192 && core_decrypt && core_keylen == 2'd1};
            end else if (core_rsp_valid) begin
                pend <= 1'b0;
            end else if (pend) begin
                wait_cnt <= wait_cnt + 1;
            end
        end
        if (done) n_done <= n_done + 1;
        if (!rst && held && core_req &&
            held_fields !== {core_decrypt, core_keylen, core_key, core_in})
            unstable <= unstable + 1;
        held        <= !rst && core_req && !core_ack;
        held_fields <= {core_decrypt, core_keylen, core_key, core_in};
    end

    // Masked core model: ideal timing, logs issued key lengths
    int         n_hs_m = 0;
    logic [1:0] kl_log [8];

    assign ack_m = req_m;

    always @(posedge clk) begin
        vld_m  <= !rst && req_m && ack_m;
        data_m <= ref_aes(dec_m, kl_m, key_m, in_m);
        if (!rst && req_m && ack_m) begin
            if (n_hs_m < 8) kl_log[n_hs_m] <= kl_m;
            n_hs_m <= n_hs_m + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pulse start and wait for done; optionally re-pulse start at cycle restart_at.
    task automatic run(input int restart_at, output int cyc);
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (done) break;
        end
        start = 1'b0;
        chk("run_reached_done", done, 1'b1);
    endtask

    int cyc;
    int hs0;
    int dn0;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy_done", {busy, done}, 2'b00);
        chk("reset_pass_flags", {pass, all_pass, timeout}, 8'h00);
        chk("reset_core_fields", {core_req, core_decrypt, core_keylen, core_key, core_in}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {busy, core_req}, 2'b00);

        // Ideal core
        hs0 = n_hs;
        dn0 = n_done;
        run(0, cyc);
        chk("ideal_latency", cyc, 19);
        chk("ideal_pass", pass, 6'b111111);
        chk("ideal_all_pass", all_pass, 1'b1);
        chk("ideal_timeout", timeout, 1'b0);
        chk("ideal_busy_in_done", busy, 1'b0);
        chk("ideal_requests", n_hs - hs0, 6);
        // start coinciding with DONE must be ignored
        hs0 = n_hs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("start_in_done_ignored", {busy, core_req}, 2'b00);
        chk("start_in_done_no_req", n_hs - hs0, 0);
        chk("ideal_done_pulses", n_done - dn0, 1);
        chk("all_pass_held", all_pass, 1'b1);

        // Corrupt bit 0 of the d192 result
        corrupt_d192 = 1'b1;
        run(0, cyc);
        corrupt_d192 = 1'b0;
        chk("corrupt_pass", pass, 6'b110111);
        chk("corrupt_all_pass", all_pass, 1'b0);

        // Backpressure: ack after 5 cycles, response after 7
        ack_dly = 5;
        rsp_dly = 7;
        run(0, cyc);
        chk("bp_latency", cyc, 79);
        chk("bp_pass", pass, 6'b111111);
        chk("bp_all_pass", all_pass, 1'b1);
        chk("bp_fields_stable", unstable, 0);
        ack_dly = 1;
        rsp_dly = 1;

        // Masked instance: only e128 and e256
        @(negedge clk);
        start_m = 1'b1;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start_m = 1'b0;
            cyc++;
            if (done_m) break;
        end
        chk("mask_reached_done", done_m, 1'b1);
        chk("mask_latency", cyc, 7);
        chk("mask_requests", n_hs_m, 2);
        chk("mask_keylen_first", kl_log[0], 2'd0);
        chk("mask_keylen_second", kl_log[1], 2'd2);
        chk("mask_pass", pass_m, 6'b010001);
        chk("mask_all_pass", all_pass_m, 1'b1);

        // Reset while waiting for the third response
        hs0 = n_hs;
        dn0 = n_done;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (n_hs - hs0 == 3) break;
        end
        chk("midrun_in_wait", {n_hs - hs0 == 3, busy, core_req}, 3'b110);
        chk("midrun_partial_pass", pass, 6'b000011);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_outputs", {busy, done, core_req, all_pass}, 4'b0000);
        chk("midrun_rst_pass", pass, 6'b000000);
        repeat (5) @(negedge clk);
        chk("midrun_no_done", n_done - dn0, 0);
        chk("midrun_stays_idle", {busy, core_req}, 2'b00);

        // Clean restart with a stray start pulse while busy
        hs0 = n_hs;
        run(5, cyc);
        chk("restart_latency", cyc, 19);
        chk("restart_pass", pass, 6'b111111);
        chk("restart_requests", n_hs - hs0, 6);
        repeat (3) @(negedge clk);
        chk("restart_done_pulses", n_done - dn0, 1);

`ifdef AES_KAT_TIMEOUT_EN
        // Core never responds to e192: watchdog expires after 16 cycles
        drop_e192 = 1'b1;
        run(0, cyc);
        drop_e192 = 1'b0;
        chk("tmo_latency", cyc, 33);
        chk("tmo_pass", pass, 6'b111011);
        chk("tmo_flag", timeout, 1'b1);
        chk("tmo_all_pass", all_pass, 1'b0);
        repeat (2) @(negedge clk);
        chk("tmo_sticky", timeout, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_kat_sequencer.md
Name: aes_kat_sequencer

Overview:
Sequential known-answer-test (KAT) controller for one shared AES engine that supports all key sizes and both directions.
On a start pulse it runs up to six vectors through the engine over a request/response handshake, compares each result, and latches per-test pass flags. The six vectors are encrypt and decrypt at 128, 192 and 256 bits.
It sits between the power-on/BIST control logic and the shared AES core, and replaces six parallel combinational instances with one time-multiplexed engine.

Parameters:
TEST_MASK, 6'b111111, enable per test; bit order [0]=e128 [1]=d128 [2]=e192 [3]=d192 [4]=e256 [5]=d256
TIMEOUT_CYCLES, 1023, watchdog limit per test (used only with AES_KAT_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse to begin a run; ignored while busy
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of run
pass  out  6  per-test result, held until the next start (bit order as TEST_MASK)
all_pass  out  1  &(pass | ~TEST_MASK), valid while done=1 and held afterwards
timeout  out  1  sticky: some test hit the watchdog (tied 0 without the macro)
core_req  out  1  request to AES core; held high until core_ack
core_decrypt  out  1  0=encrypt, 1=decrypt
core_keylen  out  2  0=128, 1=192, 2=256
core_key  out  256  key, left-aligned; unused LSBs are 0
core_in  out  128  plaintext or ciphertext
core_ack  in  1  core accepted the request this cycle
core_rsp_valid  in  1  result valid this cycle
core_rsp_data  in  128  result

Behaviour:
- Reset values: busy=0, done=0, pass=0, all_pass=0, timeout=0, core_req=0, core_decrypt=0, core_keylen=0, core_key=0, core_in=0, state=IDLE, idx=0.
- Vectors (FIPS-197 App. C):
  - Plaintext 00112233445566778899aabbccddeeff.
  - Keys are the 16/24/32-byte ramps 000102... .
  - Ciphertexts: 128 = 69c4e0d86a7b0430d8cdb78070b4c55a; 192 = dda97ca4864cdfe06eaf70a0ec0d7191; 256 = 8ea2b7ca516745bfeafc49904b496089.
- Encrypt tests: core_in=plaintext, expect the ciphertext. Decrypt tests: core_in=the constant ciphertext (not the encrypt result), expect the plaintext.
- IDLE: start=1 -> clear pass and timeout, set idx to the lowest enabled test, go to ISSUE.
  - TEST_MASK=0 -> go straight to DONE.
- ISSUE: core_req=1 with stable core_* fields. On core_ack=1 -> WAIT. core_req drops the following cycle.
- WAIT: core_rsp_valid is sampled only in this state; capture the result -> CHECK. rsp_valid outside WAIT is ignored.
- CHECK: pass[idx] <= (captured == expected).
  - Another enabled test remains -> advance idx to it, go to ISSUE.
  - Otherwise -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Minimum latency (ack same cycle as req, rsp the next cycle) is 3 cycles per test plus 1 DONE cycle: 19 cycles start-to-done for a full mask.
- Disabled tests are never issued and their pass bit stays 0.
- start during busy is ignored. start coinciding with DONE is ignored.
- rst mid-run: return to IDLE next edge, core_req drops immediately, no done pulse, pass cleared.

Optional Feature:
AES_KAT_TIMEOUT_EN
- Defined:
  - A per-test counter clears on entering ISSUE and counts every cycle in ISSUE/WAIT.
  - At TIMEOUT_CYCLES: pass[idx]=0, timeout=1 (sticky), core_req drops, and the run proceeds as in CHECK to the next test.
  - A late core_rsp_valid is ignored.
- Undefined: no counter, timeout tied 0; the FSM waits indefinitely.

Decomposition:
- Package aes_kat_pkg holds:
  - keylen encodings;
  - test-index constants;
  - the plaintext, three keys and three ciphertext constants;
  - a function mapping idx to (decrypt, keylen, key, in, expected).
- Sub-module aes_kat_rom: combinational idx -> vector fields, so the FSM stays vector-agnostic.

Test Plan:
- Ideal core model (ack same cycle, rsp +1, correct AES): pulse start -> done at cycle 19, pass=6'b111111, all_pass=1, timeout=0.
- Core model corrupts bit 0 of the d192 result: full run -> pass=6'b110111, all_pass=0.
- Backpressure (ack after 5 cycles, rsp after 7): core_req and core_* held stable until ack; pass=111111; done at cycle 6*(5+7+1)+1 = 79 from start.
- TEST_MASK=6'b010001: only e128 and e256 are issued (core_keylen 0 then 2); pass=010001, all_pass=1.
- rst asserted in WAIT of test 3, then start: clean restart, pass cleared, second run passes fully; a start pulse during busy causes no extra requests.
- With AES_KAT_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never responds to e192 -> pass[2]=0, timeout=1, remaining tests still pass.
